// File: rtl/mux_8_32_pkg.sv
// Shared constants and FSM state encoding for the 8-to-32 byte assembler.
package mux_8_32_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // State value equals the number of bytes currently held in the shift register
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t B1   = 2'd1;
  localparam state_t B2   = 2'd2;
  localparam state_t B3   = 2'd3;

endpackage

// File: rtl/mux_8_32_if.sv
// Byte-in / word-out bus of mux_8_32.
// err_out exists only when MUX_8_32_ERR_EN is defined.
interface mux_8_32_if;
  import mux_8_32_pkg::*;

  logic [BYTE_W-1:0] data_in;
  logic              valid_in;
  logic [WORD_W-1:0] lane_0;
  logic              valid_0;
`ifdef MUX_8_32_ERR_EN
  logic              err_out;
`endif

  // Byte source side
  modport master (
    output data_in, valid_in,
    input  lane_0, valid_0
`ifdef MUX_8_32_ERR_EN
    , input err_out
`endif
  );

  // Assembler side
  modport slave (
    input  data_in, valid_in,
    output lane_0, valid_0
`ifdef MUX_8_32_ERR_EN
    , output err_out
`endif
  );

endinterface

// File: rtl/mux_8_32_byte_shift_reg.sv
// 32-bit word register with byte-indexed load (index 0 = MSB) and clear.
module byte_shift_reg
  import mux_8_32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [1:0]        idx,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out
);

  logic [WORD_W-1:0] word_d, word_q;

  // Clear has priority; otherwise write byte_in into the indexed byte lane
  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (load) begin
      case (idx)
        2'd0:    word_d[31:24] = byte_in;
        2'd1:    word_d[23:16] = byte_in;
        2'd2:    word_d[15:8]  = byte_in;
        default: word_d[7:0]   = byte_in;
      endcase
    end
  end

  // Word storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign word_out = word_q;

endmodule

// File: rtl/mux_8_32.sv
// Assembles a serial MSB-first byte stream into 32-bit words on lane_0.
// A gap in valid_in mid-word discards the partial word.
// Optional abort pulse err_out is enabled by defining MUX_8_32_ERR_EN.
module mux_8_32
  import mux_8_32_pkg::*;
(
  input  logic       clk_4f,
  input  logic       reset,
  mux_8_32_if.slave  bus
);

  state_t            state_d, state_q;
  logic [WORD_W-1:0] lane_d, lane_q;
  logic              valid_d, valid_q;
  logic              sr_load, sr_clr;
  logic [WORD_W-1:0] sr_word;
`ifdef MUX_8_32_ERR_EN
  logic              err_d, err_q;
`endif

  byte_shift_reg u_sr (
    .clk      (clk_4f),
    .rst      (reset),
    .clr      (sr_clr),
    .load     (sr_load),
    .idx      (state_q),
    .byte_in  (bus.data_in),
    .word_out (sr_word)
  );

  // Next-state, shift register control and output register inputs
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    valid_d = 1'b0;
    sr_load = 1'b0;
    sr_clr  = 1'b0;
`ifdef MUX_8_32_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          sr_load = 1'b1;
          state_d = B1;
        end
      end
      B1, B2: begin
        if (bus.valid_in) begin
          sr_load = 1'b1;
          state_d = state_q + 2'd1;
        end else begin
          sr_clr  = 1'b1;
          state_d = IDLE;
`ifdef MUX_8_32_ERR_EN
          err_d   = 1'b1;
`endif
        end
      end
      default: begin
        if (bus.valid_in) begin
          // Low byte of the shift register is never loaded and is cleared on
          // every return to IDLE, so OR-ing in data_in gives {sr[31:8], data_in}
          lane_d  = sr_word | {{(WORD_W-BYTE_W){1'b0}}, bus.data_in};
          valid_d = 1'b1;
        end
`ifdef MUX_8_32_ERR_EN
        else begin
          err_d   = 1'b1;
        end
`endif
        sr_clr  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
    end
  end

`ifdef MUX_8_32_ERR_EN
  // Abort pulse register
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err_out = err_q;
`endif

  assign bus.lane_0  = lane_q;
  assign bus.valid_0 = valid_q;

endmodule
